// File: rtl/kbest_pkg.sv
// Shared types and helpers for the K-best tree-search layer engine.
package kbest_pkg;

   localparam int KB_PEDW = 24;
   localparam int KB_PIDW = 6;
   localparam int KB_SYMW = 3;

   typedef enum logic [1:0] {ACCEPT, EXPAND, DRAIN} state_e;

   typedef struct packed {
      logic [KB_PEDW-1:0]        ped;
      logic [KB_PIDW-1:0]        pid;
      logic signed [KB_SYMW-1:0] sym;
   } survivor_t;

   // PAM symbol for child index c: -(M-1), ..., +(M-1) in steps of 2
   function automatic int sym_of(input int c, input int m);
      return 2 * c - (m - 1);
   endfunction

   function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int w);
      logic [64:0] s;
      logic [64:0] mx;
      s  = {1'b0, a} + {1'b0, b};
      mx = (65'd1 << w) - 65'd1;
      return (s > mx) ? mx[63:0] : s[63:0];
   endfunction

endpackage

// File: rtl/kbest_layer_engine_list.sv
// Ascending sorted survivor list: parallel compare/insert, pop-front and clear.
module kbest_sorted_list
   import kbest_pkg::*;
#(
   parameter int  K = 8,
   parameter type T = survivor_t
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     clear_i,
   input  logic                     ins_i,
   input  T                         ins_d_i,
   input  logic                     pop_i,
   output T                         head_d_o,
   output logic [$clog2(K+1)-1:0]   cnt_o,
   output logic [$clog2(K+1)-1:0]   cnt_d_o
);

   localparam int CW = $clog2(K+1);

   T               ent_q [K];
   T               ent_d [K];
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [K-1:0]   ge;

   // ge is monotonic over a sorted list, so the first set bit is the insert slot;
   // a full list with no strictly greater entry leaves everything untouched.
   always_comb begin
      ent_d = ent_q;
      cnt_d = cnt_q;
      for (int i = 0; i < K; i++)
         ge[i] = (CW'(i) >= cnt_q) || (ent_q[i].ped > ins_d_i.ped);
      if (clear_i) begin
         cnt_d = '0;
      end else if (pop_i) begin
         for (int i = 0; i < K-1; i++) ent_d[i] = ent_q[i+1];
         cnt_d = cnt_q - CW'(1);
      end else if (ins_i) begin
         if (ge[0]) ent_d[0] = ins_d_i;
         for (int i = 1; i < K; i++)
            if (ge[i]) ent_d[i] = ge[i-1] ? ent_q[i-1] : ins_d_i;
         if (cnt_q != CW'(K)) cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
         for (int i = 0; i < K; i++) ent_q[i] <= '0;
      end else begin
         cnt_q <= cnt_d;
         ent_q <= ent_d;
      end
   end

   assign head_d_o = ent_d[0];
   assign cnt_o    = cnt_q;
   assign cnt_d_o  = cnt_d;

endmodule

// File: rtl/kbest_layer_engine.sv
// K-best layer: expands each parent into M PAM children, keeps the K smallest
// PEDs sorted, then drains them in ascending order.
module kbest_layer_engine
   import kbest_pkg::*;
#(
   parameter int DW   = 16,
   parameter int PEDW = 24,
   parameter int K    = 8,
   parameter int M    = 4,
   parameter int PIDW = 6
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    flush,
   input  logic signed [DW-1:0]    y,
   input  logic signed [DW-1:0]    r_diag,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [PEDW-1:0]         in_ped,
   input  logic signed [DW-1:0]    in_interf,
   input  logic [PIDW-1:0]         in_pid,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [PEDW-1:0]         out_ped,
   output logic [PIDW-1:0]         out_pid,
   output logic signed [$clog2(M):0] out_sym,
   output logic                    out_last,
   output logic                    busy
);

   localparam int SYMW = $clog2(M) + 1;
   localparam int CBW  = $clog2(M);
   localparam int EW   = DW + $clog2(M) + 2;
   localparam int CW   = $clog2(K+1);

   typedef struct packed {
      logic [PEDW-1:0]        ped;
      logic [PIDW-1:0]        pid;
      logic signed [SYMW-1:0] sym;
   } entry_t;

   state_e                 state_q;
   logic [CBW-1:0]         c_q;
   logic [PEDW-1:0]        ped_q;
   logic signed [DW-1:0]   interf_q;
   logic [PIDW-1:0]        pid_q;
   logic                   last_q;
   logic                   in_ready_q, out_valid_q, out_last_q;
   logic [PEDW-1:0]        out_ped_q;
   logic [PIDW-1:0]        out_pid_q;
   logic signed [SYMW-1:0] out_sym_q;

   logic signed [SYMW-1:0] sym;
   logic [CBW-1:0]         mag;
   logic signed [EW-1:0]   r_ext, rs_acc, rs, e;
   logic signed [2*EW-1:0] esq;
   logic [63:0]            ped_sum;
   entry_t                 ins_d, head_d;
   logic                   ins, pop, drain_nxt;
   logic [CW-1:0]          cnt, cnt_d;

   // r_diag*sym as shift-add over |sym|; the square is the only multiplier
   always_comb begin
      sym    = SYMW'(sym_of(int'(c_q), M));
      mag    = sym[SYMW-1] ? CBW'(-sym) : CBW'(sym);
      r_ext  = EW'(r_diag);
      rs_acc = '0;
      for (int b = 0; b < CBW; b++)
         if (mag[b]) rs_acc = rs_acc + (r_ext <<< b);
      rs      = sym[SYMW-1] ? -rs_acc : rs_acc;
      e       = EW'(y) - EW'(interf_q) - rs;
      esq     = (2*EW)'(e) * (2*EW)'(e);
      ped_sum = sat_add(64'(ped_q), 64'(esq), PEDW);
      ins_d   = '{ped: ped_sum[PEDW-1:0], pid: pid_q, sym: sym};
   end

   assign ins = (state_q == EXPAND);
   assign pop = (state_q == DRAIN) && out_valid_q && out_ready;
   assign drain_nxt = ((state_q == EXPAND) && (c_q == CBW'(M-1)) && last_q) ||
                      ((state_q == DRAIN) && !(pop && (cnt == CW'(1))));

   kbest_sorted_list #(.K(K), .T(entry_t)) u_list (
      .clk      (clk),
      .rstn     (rstn),
      .clear_i  (flush),
      .ins_i    (ins),
      .ins_d_i  (ins_d),
      .pop_i    (pop),
      .head_d_o (head_d),
      .cnt_o    (cnt),
      .cnt_d_o  (cnt_d)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ACCEPT;
         c_q         <= '0;
         ped_q       <= '0;
         interf_q    <= '0;
         pid_q       <= '0;
         last_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_ped_q   <= '0;
         out_pid_q   <= '0;
         out_sym_q   <= '0;
      end else if (flush) begin
         state_q     <= ACCEPT;
         c_q         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_ped_q   <= '0;
         out_pid_q   <= '0;
         out_sym_q   <= '0;
      end else begin
         case (state_q)
            ACCEPT: begin
               in_ready_q <= 1'b1;
               if (in_valid && in_ready_q) begin
                  ped_q      <= in_ped;
                  interf_q   <= in_interf;
                  pid_q      <= in_pid;
                  last_q     <= in_last;
                  c_q        <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= EXPAND;
               end
            end
            EXPAND: begin
               c_q <= c_q + CBW'(1);
               if (c_q == CBW'(M-1)) begin
                  state_q    <= last_q ? DRAIN : ACCEPT;
                  in_ready_q <= !last_q;
               end
            end
            DRAIN: begin
               if (pop && (cnt == CW'(1))) begin
                  state_q    <= ACCEPT;
                  in_ready_q <= 1'b1;
               end
            end
            default: state_q <= ACCEPT;
         endcase
         // output registers track the list head as it will be after this edge
         out_valid_q <= drain_nxt;
         out_last_q  <= drain_nxt && (cnt_d == CW'(1));
         out_ped_q   <= drain_nxt ? head_d.ped : '0;
         out_pid_q   <= drain_nxt ? head_d.pid : '0;
         out_sym_q   <= drain_nxt ? head_d.sym : '0;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_ped   = out_ped_q;
   assign out_pid   = out_pid_q;
   assign out_sym   = out_sym_q;
   assign busy      = !((state_q == ACCEPT) && (cnt == '0));

endmodule
